// File: rtl/alu_pkg.sv
// Shared definitions for the yAlu sharing controller: op codes, legality check, FSM states.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, ptr selects the winner only on a tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin scheduler sharing one combinational yAlu between two requesters.
// Optional golden-model self-check enabled by defining ALU_SHARE_CHECK_EN.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2:0]       req_op0,
    input  logic [2:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_z,
    output logic             rsp_ex,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_z,
    input  logic             alu_ex,
    output logic             chk_mismatch
);

    state_t           state;
    logic             ptr;
    logic             g_p0;
    logic [1:0]       gnt;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    rr_arb2 u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt)
    );

    assign sel_op    = gnt[1] ? req_op1 : req_op0;
    assign sel_a     = gnt[1] ? req_a1  : req_a0;
    assign sel_b     = gnt[1] ? req_b1  : req_b0;
    assign req_ready = (state == ST_IDLE) ? (gnt & req_valid) : 2'b00;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= 1'b0;
            g_p0      <= 1'b0;
            rsp_valid <= 2'b00;
            rsp_z     <= '0;
            rsp_ex    <= 1'b0;
            rsp_err   <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= OP_AND;
        end else begin
            case (state)
                // Accept: illegal ops bypass the ALU so its inputs keep their last value
                ST_IDLE: begin
                    if (|req_valid) begin
                        g_p0 <= gnt[1];
                        if (op_legal(sel_op)) begin
                            alu_a  <= sel_a;
                            alu_b  <= sel_b;
                            alu_op <= sel_op;
                            state  <= ST_EXEC;
                        end else begin
                            rsp_z     <= '0;
                            rsp_ex    <= 1'b0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= gnt;
                            state     <= ST_RESP;
                        end
                    end
                end
                // Execute: capture the combinational ALU result
                ST_EXEC: begin
                    rsp_z     <= alu_z;
                    rsp_ex    <= alu_ex;
                    rsp_err   <= 1'b0;
                    rsp_valid <= g_p0 ? 2'b10 : 2'b01;
                    state     <= ST_RESP;
                end
                // Respond: only the granted requester's rsp_ready completes the handshake
                ST_RESP: begin
                    if (rsp_ready[g_p0]) begin
                        rsp_valid <= 2'b00;
                        ptr       <= ~g_p0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_SHARE_CHECK_EN
    function automatic logic [WIDTH-1:0] golden(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return {{(WIDTH-1){1'b0}}, (sa < sb)};
            default: return '0;
        endcase
    endfunction

    logic chk_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_q <= 1'b0;
        end else if ((state == ST_EXEC) && (golden(alu_op, alu_a, alu_b) != alu_z)) begin
            chk_q <= 1'b1;
        end
    end

    assign chk_mismatch = chk_q;
`else
    assign chk_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl with a behavioural yAlu attached.
module tb_alu_share_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [2:0]   req_op0, req_op1;
    logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [W-1:0] rsp_z;
    logic         rsp_ex;
    logic         rsp_err;
    logic [W-1:0] alu_a, alu_b;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_z;
    logic         alu_ex;
    logic         chk_mismatch;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_z(rsp_z), .rsp_ex(rsp_ex), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_z(alu_z), .alu_ex(alu_ex),
        .chk_mismatch(chk_mismatch)
    );

    // Behavioural yAlu: signed overflow on ADD/SUB only
    always_comb begin
        alu_z  = '0;
        alu_ex = 1'b0;
        case (alu_op)
            3'b000: alu_z = alu_a & alu_b;
            3'b001: alu_z = alu_a | alu_b;
            3'b010: begin
                alu_z  = alu_a + alu_b;
                alu_ex = (alu_a[W-1] == alu_b[W-1]) && (alu_z[W-1] != alu_a[W-1]);
            end
            3'b110: begin
                alu_z  = alu_a - alu_b;
                alu_ex = (alu_a[W-1] != alu_b[W-1]) && (alu_z[W-1] != alu_a[W-1]);
            end
            3'b111: alu_z = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: alu_z = '0;
        endcase
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input logic r, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        if (r) begin
            req_op1 = op; req_a1 = a; req_b1 = b;
        end else begin
            req_op0 = op; req_a0 = a; req_b0 = b;
        end
    endtask

    typedef struct {
        logic         r;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] z;
        logic         ex;
        logic         err;
    } vec_t;

    vec_t vt[9];

    initial begin
        logic [2:0] prev_op;
        logic [1:0] onehot;
        logic       legal;

        vt[0] = '{1'b0, 3'b010, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0, 1'b0};
        vt[1] = '{1'b1, 3'b110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vt[2] = '{1'b0, 3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0};
        vt[3] = '{1'b1, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
        vt[4] = '{1'b0, 3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0};
        vt[5] = '{1'b1, 3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
        vt[6] = '{1'b0, 3'b011, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1};
        vt[7] = '{1'b1, 3'b100, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b0, 1'b1};
        vt[8] = '{1'b0, 3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0};

        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        set_req(1'b0, 3'b000, '0, '0);
        set_req(1'b1, 3'b000, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        chk("reset req_ready", {30'd0, req_ready}, 0);
        chk("reset rsp_valid", {30'd0, rsp_valid}, 0);
        chk("reset rsp_z", rsp_z, 0);
        chk("reset rsp_ex_err", {30'd0, rsp_ex, rsp_err}, 0);
        chk("reset alu_a", alu_a, 0);
        chk("reset alu_b", alu_b, 0);
        chk("reset alu_op", {29'd0, alu_op}, 0);
        chk("reset chk_mismatch", {31'd0, chk_mismatch}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Contention: both requesters valid from reset
        set_req(1'b0, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        set_req(1'b1, 3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00);
        req_valid = 2'b11;
        #1 chk("tie1 req_ready", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        chk("tie1 exec req_ready", {30'd0, req_ready}, 0);
        chk("tie1 exec rsp_valid", {30'd0, rsp_valid}, 0);
        @(negedge clk);
        chk("tie1 rsp_valid", {30'd0, rsp_valid}, 32'd1);
        chk("tie1 rsp_z", rsp_z, 32'hF000_F000);
        @(negedge clk);
        chk("tie2 req_ready", {30'd0, req_ready}, 32'd2);
        @(negedge clk);
        @(negedge clk);
        chk("tie2 rsp_valid", {30'd0, rsp_valid}, 32'd2);
        chk("tie2 rsp_z", rsp_z, 32'hFFF0_FFF0);
        @(negedge clk);
        chk("tie3 req_ready", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b00;
        @(negedge clk);

        // Backpressure on requester 1 while requester 0 waits
        rsp_ready = 2'b00;
        set_req(1'b1, 3'b110, 32'd3, 32'd5);
        set_req(1'b0, 3'b010, 32'd1, 32'd1);
        req_valid = 2'b10;
        #1 chk("bp accept req_ready", {30'd0, req_ready}, 32'd2);
        @(negedge clk);
        req_valid = 2'b11;
        #1 chk("bp exec req_ready", {30'd0, req_ready}, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) rsp_ready = 2'b01;
            #1;
            chk($sformatf("bp hold%0d rsp_valid", i), {30'd0, rsp_valid}, 32'd2);
            chk($sformatf("bp hold%0d rsp_z", i), rsp_z, 32'hFFFF_FFFE);
            chk($sformatf("bp hold%0d req_ready", i), {30'd0, req_ready}, 0);
        end
        @(negedge clk);
        chk("bp wrong ready ignored", {30'd0, rsp_valid}, 32'd2);
        rsp_ready = 2'b10;
        @(negedge clk);
        chk("bp done rsp_valid", {30'd0, rsp_valid}, 0);
        chk("bp waiter req_ready", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        @(negedge clk);

        // Table of single-requester transactions
        for (int k = 0; k < 9; k++) begin
            legal = (vt[k].err == 1'b0);
            onehot = vt[k].r ? 2'b10 : 2'b01;
            prev_op = alu_op;
            set_req(vt[k].r, vt[k].op, vt[k].a, vt[k].b);
            req_valid = onehot;
            #1 chk($sformatf("v%0d req_ready", k), {30'd0, req_ready}, {30'd0, onehot});
            @(negedge clk);
            req_valid = 2'b00;
            if (legal) begin
                chk($sformatf("v%0d exec rsp_valid", k), {30'd0, rsp_valid}, 0);
                chk($sformatf("v%0d alu_op", k), {29'd0, alu_op}, {29'd0, vt[k].op});
                chk($sformatf("v%0d alu_a", k), alu_a, vt[k].a);
                @(negedge clk);
            end else begin
                chk($sformatf("v%0d alu_op kept", k), {29'd0, alu_op}, {29'd0, prev_op});
            end
            chk($sformatf("v%0d rsp_valid", k), {30'd0, rsp_valid}, {30'd0, onehot});
            chk($sformatf("v%0d rsp_z", k), rsp_z, vt[k].z);
            chk($sformatf("v%0d rsp_ex", k), {31'd0, rsp_ex}, {31'd0, vt[k].ex});
            chk($sformatf("v%0d rsp_err", k), {31'd0, rsp_err}, {31'd0, vt[k].err});
            @(negedge clk);
            chk($sformatf("v%0d idle rsp_valid", k), {30'd0, rsp_valid}, 0);
        end
        chk("chk_mismatch clear", {31'd0, chk_mismatch}, 0);

        // Reset while requester 1's response is pending (pointer currently favours 1)
        rsp_ready = 2'b00;
        set_req(1'b1, 3'b010, 32'd2, 32'd2);
        req_valid = 2'b10;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        chk("rr pending rsp_valid", {30'd0, rsp_valid}, 32'd2);
        chk("rr pending rsp_z", rsp_z, 32'd4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rr rsp_valid", {30'd0, rsp_valid}, 0);
        chk("rr rsp_z", rsp_z, 0);
        chk("rr alu_a", alu_a, 0);
        chk("rr alu_op", {29'd0, alu_op}, 0);
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("rr no completion", {30'd0, rsp_valid}, 0);
        req_valid = 2'b11;
        #1 chk("rr tie to 0", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b00;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-requester scheduler for the shared 32-bit yAlu datapath (AND/OR/ADD/SUB/SLT with overflow flag `ex`). Accepts operations from two independent requesters over valid/ready handshakes, arbitrates round-robin, drives the external combinational ALU from registered operands, captures result and `ex`, and returns them to the winning requester. Sits between the lab's control front-ends and the single yAlu instance.

## Interface
- `WIDTH`, 32, operand/result width; must match the attached yAlu.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `req_valid`  in  2  per-requester operation valid.
- `req_ready`  out  2  per-requester accept; at most one bit set.
- `req_op0`, `req_op1`  in  3 each  ALU op code per requester.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  WIDTH each  operands.
- `rsp_valid`  out  2  per-requester response valid; at most one bit set.
- `rsp_ready`  in  2  per-requester response accept.
- `rsp_z`  out  WIDTH  result (shared by both requesters).
- `rsp_ex`  out  1  overflow flag from ALU.
- `rsp_err`  out  1  illegal op code flag.
- `alu_a`, `alu_b`  out  WIDTH  to yAlu.
- `alu_op`  out  3  to yAlu.
- `alu_z`  in  WIDTH  from yAlu.
- `alu_ex`  in  1  from yAlu.
- `chk_mismatch`  out  1  sticky self-check failure (see Configuration).

## Operation
- Legal ops: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT. Any other code is illegal.
- FSM states IDLE, EXEC, RESP.
- IDLE: if any `req_valid`, grant one requester. With both valid, grant the requester the RR pointer names. With one valid, grant it regardless of the pointer.
- `req_ready[g] = (state==IDLE) & req_valid[g]` for the granted requester g only. On the accept edge, latch op, a, b and g.
  - Legal op -> EXEC.
  - Illegal op -> RESP with z=0, ex=0, err=1. The ALU is not exercised.
- EXEC: `alu_a/alu_b/alu_op` driven from the latched registers. On the next edge, latch `alu_z` and `alu_ex` into `rsp_z` and `rsp_ex`, set err=0, go to RESP.
- RESP: `rsp_valid[g]=1`. Hold `rsp_z`, `rsp_ex` and `rsp_err` stable until `rsp_ready[g]`.
  - On the handshake edge: go to IDLE and set the RR pointer to ~g.
  - `rsp_ready` of the non-granted requester is ignored.
- No new request is accepted while in EXEC or RESP, so a requester may drop `req_valid` freely while not granted.
- `alu_*` outputs hold their last latched value outside EXEC.
- Arithmetic is fully delegated to the ALU. The block does no width extension; `rsp_z` is exactly WIDTH bits.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_z`=0, `rsp_ex`=0, `rsp_err`=0, `alu_a`=0, `alu_b`=0, `alu_op`=000, `chk_mismatch`=0, state=IDLE, RR pointer=0 (requester 0 has priority).
- Legal op accepted at edge N: `rsp_valid` is high from N+2.
- Illegal op accepted at edge N: `rsp_valid` is high from N+1.
- With `rsp_ready` tied high, throughput is one legal op per 3 cycles, or one illegal op per 2 cycles.
- Reset asserted in any state takes effect at the next edge. Any in-flight or pending response is discarded without a handshake.
- `req_ready` is combinational from state and `req_valid`. `rsp_*` outputs are registered.

## Configuration
- `ALU_SHARE_CHECK_EN` defined:
  - An internal golden model recomputes the legal op from the latched operands in EXEC and compares it with `alu_z`.
  - Any difference sets `chk_mismatch`, which stays set until reset.
- `ALU_SHARE_CHECK_EN` undefined: the model is absent and `chk_mismatch` is tied to 0.

## Structure
- Shared package `alu_pkg`:
  - op code localparams `OP_AND`, `OP_OR`, `OP_ADD`, `OP_SUB`, `OP_SLT`;
  - function `op_legal`;
  - FSM state typedef/encoding.
- One sub-module, `rr_arb2`: 2-way round-robin grant from request bits and pointer, producing a one-hot grant. FSM, registers and the check live in `alu_share_ctrl`.

## Test plan
- Single request: requester 0, op=010, a=5, b=7, `rsp_ready`=1 -> `req_ready[0]` on the accept cycle, `rsp_valid[0]` two cycles later, z=12, ex=0, err=0.
- Contention: both valid from reset with op0=000 and op1=001, a=0xF0F0F0F0, b=0xFF00FF00.
  - Requester 0 served first, z=0xF000F000.
  - Requester 1 served next, z=0xFFF0FFF0.
  - Next tie goes to requester 0 again.
- Backpressure: op=110, a=3, b=5, `rsp_ready` held 0 for 4 cycles -> `rsp_valid` and z=0xFFFFFFFE held stable throughout; no `req_ready` to the other waiting requester until the handshake.
- Illegal op=011 -> response one cycle after accept with z=0, err=1; `alu_op` unchanged.
- Overflow: op=010, a=0x7FFFFFFF, b=1 -> z=0x80000000, ex=1.
- Reset in RESP: `rst_n` low for one cycle while `rsp_valid[1]`=1 -> all outputs at reset values next cycle; the pending response never completes; requester 0 wins the next tie.
